relu_seq_ctrl: RTL and testbench

RELU_SEQ_CTRL -- requirements
Module: relu_seq_ctrl

---
 rtl/relu_seq_ctrl.sv | 164 ++++++++++++++++
 tb/tb_relu_seq_ctrl.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/relu_seq_ctrl.sv
// Sequencer that streams one feature map from a source buffer through the ReLU into a destination
// buffer. Define RELU_SEQ_ZERO_CNT_EN to build the counter of outputs clamped to zero.
module relu_seq_ctrl #(
    parameter int unsigned BIT_WIDTH  = 32,
    parameter int unsigned ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_start,
    input  logic [ADDR_WIDTH:0]   i_len,
    input  logic                  i_abort,
    input  logic                  i_hold,
    output logic                  o_rd_en,
    output logic [ADDR_WIDTH-1:0] o_rd_addr,
    output logic                  o_relu_ce,
    output logic                  o_relu_clr,
    input  logic                  i_relu_ce,
    input  logic [BIT_WIDTH-1:0]  i_relu_data,
    output logic                  o_wr_en,
    output logic [ADDR_WIDTH-1:0] o_wr_addr,
    output logic [BIT_WIDTH-1:0]  o_wr_data,
    output logic                  o_busy,
    output logic                  o_done,
    output logic [ADDR_WIDTH:0]   o_zero_cnt
);

    typedef enum logic [2:0] {
        StIdle,
        StClear,
        StRun,
        StDrain,
        StDone
    } state_e;

    localparam logic [ADDR_WIDTH:0] CntOne = {{ADDR_WIDTH{1'b0}}, 1'b1};

    state_e              state_q;
    logic [ADDR_WIDTH:0] len_q;
    logic [ADDR_WIDTH:0] rd_cnt_q;
    logic [ADDR_WIDTH:0] wr_cnt_q;
    logic [ADDR_WIDTH:0] wr_cnt_nxt;
    logic                relu_ce_q;
    logic                relu_clr_q;
    logic                busy_q;
    logic                done_q;

    logic start_acc;
    logic in_run;
    logic in_flow;
    logic abort_hit;
    logic rd_issue;
    logic last_rd;
    logic wr_fire;

    // Counters are one bit wider than the address so a full 2^ADDR_WIDTH run never wraps.
    always_comb begin
        start_acc  = (state_q == StIdle) && i_start;
        in_run     = (state_q == StRun);
        in_flow    = in_run || (state_q == StDrain);
        abort_hit  = i_abort && ((state_q == StClear) || in_flow);
        rd_issue   = in_run && !i_hold && !i_abort && (rd_cnt_q != len_q);
        last_rd    = rd_issue && ((rd_cnt_q + CntOne) == len_q);
        wr_fire    = in_flow && i_relu_ce && !i_abort && (wr_cnt_q != len_q);
        wr_cnt_nxt = wr_fire ? (wr_cnt_q + CntOne) : wr_cnt_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            len_q      <= '0;
            rd_cnt_q   <= '0;
            wr_cnt_q   <= '0;
            relu_ce_q  <= 1'b0;
            relu_clr_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            // ReLU enable trails the read strobe by the buffer's one-cycle read latency.
            relu_ce_q  <= rd_issue;
            relu_clr_q <= 1'b0;
            done_q     <= 1'b0;
            wr_cnt_q   <= wr_cnt_nxt;
            if (rd_issue) begin
                rd_cnt_q <= rd_cnt_q + CntOne;
            end

            if (abort_hit) begin
                state_q    <= StIdle;
                relu_clr_q <= 1'b1;
                busy_q     <= 1'b0;
            end else begin
                unique case (state_q)
                    StIdle: begin
                        if (start_acc) begin
                            len_q  <= i_len;
                            busy_q <= 1'b1;
                            if (i_len == '0) begin
                                state_q <= StDone;
                                done_q  <= 1'b1;
                            end else begin
                                state_q    <= StClear;
                                relu_clr_q <= 1'b1;
                            end
                        end
                    end
                    StClear: begin
                        rd_cnt_q <= '0;
                        wr_cnt_q <= '0;
                        state_q  <= StRun;
                    end
                    StRun: begin
                        if (last_rd) begin
                            state_q <= StDrain;
                        end
                    end
                    StDrain: begin
                        // Look at the post-write count so DONE follows the last write directly.
                        if (wr_cnt_nxt == len_q) begin
                            state_q <= StDone;
                            done_q  <= 1'b1;
                        end
                    end
                    StDone: begin
                        state_q <= StIdle;
                        busy_q  <= 1'b0;
                    end
                    default: begin
                        state_q <= StIdle;
                    end
                endcase
            end
        end
    end

    assign o_rd_en    = rd_issue;
    assign o_rd_addr  = rd_cnt_q[ADDR_WIDTH-1:0];
    assign o_relu_ce  = relu_ce_q;
    assign o_relu_clr = relu_clr_q;
    assign o_wr_en    = wr_fire;
    assign o_wr_addr  = wr_cnt_q[ADDR_WIDTH-1:0];
    assign o_wr_data  = wr_fire ? i_relu_data : '0;
    assign o_busy     = busy_q;
    assign o_done     = done_q;

`ifdef RELU_SEQ_ZERO_CNT_EN
    logic [ADDR_WIDTH:0] zero_cnt_q;

    // Cleared when a run is accepted, then held past DONE until the next start.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            zero_cnt_q <= '0;
        end else if (start_acc) begin
            zero_cnt_q <= '0;
        end else if (wr_fire && (i_relu_data == '0)) begin
            zero_cnt_q <= zero_cnt_q + CntOne;
        end
    end

    assign o_zero_cnt = zero_cnt_q;
`else
    assign o_zero_cnt = '0;
`endif

endmodule

// File: tb/tb_relu_seq_ctrl.sv
// Scoreboard bench for relu_seq_ctrl: stimulus queues expected reads, writes and done cycles,
// a negedge monitor pops and compares them. Source buffer and ReLU are modelled here.
module tb_relu_seq_ctrl;

    localparam int BW = 32;
    localparam int AW = 10;
`ifdef RELU_SEQ_ZERO_CNT_EN
    localparam bit ZeroEn = 1'b1;
`else
    localparam bit ZeroEn = 1'b0;
`endif

    typedef struct {
        int          addr;
        logic [31:0] data;
    } wr_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          i_start;
    logic [AW:0]   i_len;
    logic          i_abort;
    logic          i_hold;
    logic          o_rd_en;
    logic [AW-1:0] o_rd_addr;
    logic          o_relu_ce;
    logic          o_relu_clr;
    logic          m_ce = 1'b0;
    logic [BW-1:0] m_data = '0;
    logic [BW-1:0] buf_q = '0;
    logic          o_wr_en;
    logic [AW-1:0] o_wr_addr;
    logic [BW-1:0] o_wr_data;
    logic          o_busy;
    logic          o_done;
    logic [AW:0]   o_zero_cnt;

    logic [31:0] src_mem [0:1023];
    int  rq[$];
    wr_t wq[$];
    int  dq[$];
    int  cyc = 0;
    int  tests = 0;
    int  fails = 0;
    int  done_total = 0;
    int  runs_expected = 0;
    bit  rd_chk = 1'b1;
    bit  prev_rd_en = 1'b0;

    int vec_a [8] = '{5, -3, 0, 7, -1, 2, -8, 4};
    int vec_b [6] = '{-2, 9, 0, 3, -7, 1};
    int vec_c [3] = '{-1, 0, 6};
    int vec_e [8] = '{-5, 10, 0, 0, 3, -9, 11, 1};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    relu_seq_ctrl #(
        .BIT_WIDTH (BW),
        .ADDR_WIDTH(AW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .i_start    (i_start),
        .i_len      (i_len),
        .i_abort    (i_abort),
        .i_hold     (i_hold),
        .o_rd_en    (o_rd_en),
        .o_rd_addr  (o_rd_addr),
        .o_relu_ce  (o_relu_ce),
        .o_relu_clr (o_relu_clr),
        .i_relu_ce  (m_ce),
        .i_relu_data(m_data),
        .o_wr_en    (o_wr_en),
        .o_wr_addr  (o_wr_addr),
        .o_wr_data  (o_wr_data),
        .o_busy     (o_busy),
        .o_done     (o_done),
        .o_zero_cnt (o_zero_cnt)
    );

    // Source buffer (1-cycle read) feeding a 1-cycle ReLU with synchronous clear.
    always @(posedge clk) begin
        if (o_rd_en) buf_q <= src_mem[o_rd_addr];
        if (o_relu_clr) begin
            m_ce   <= 1'b0;
            m_data <= '0;
        end else begin
            m_ce <= o_relu_ce;
            if (o_relu_ce) m_data <= buf_q[31] ? 32'd0 : buf_q;
        end
    end

    function automatic logic [31:0] relu(input logic [31:0] v);
        return v[31] ? 32'd0 : v;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (rst) begin
            prev_rd_en = 1'b0;
        end else begin
            check("relu_ce_align", int'(o_relu_ce), int'(prev_rd_en));
            check("rd_during_hold", int'(o_rd_en && i_hold), 0);
            if (o_rd_en && rd_chk) begin
                if (rq.size() == 0) check("rd_unexpected", int'(o_rd_en), 0);
                else check("rd_addr", int'(o_rd_addr), rq.pop_front());
            end
            if (o_wr_en) begin
                if (wq.size() == 0) begin
                    check("wr_unexpected", int'(o_wr_en), 0);
                end else begin
                    wr_t e;
                    e = wq.pop_front();
                    check("wr_addr", int'(o_wr_addr), e.addr);
                    check("wr_data", int'(o_wr_data), int'(e.data));
                end
            end
            if (o_done) begin
                done_total++;
                if (dq.size() == 0) check("done_unexpected", int'(o_done), 0);
                else check("done_cycle", cyc, dq.pop_front());
            end
            prev_rd_en = o_rd_en;
        end
    end

    task automatic check_all_zero(input string tag);
        check({tag, "_rd_en"}, int'(o_rd_en), 0);
        check({tag, "_rd_addr"}, int'(o_rd_addr), 0);
        check({tag, "_relu_ce"}, int'(o_relu_ce), 0);
        check({tag, "_relu_clr"}, int'(o_relu_clr), 0);
        check({tag, "_wr_en"}, int'(o_wr_en), 0);
        check({tag, "_wr_addr"}, int'(o_wr_addr), 0);
        check({tag, "_wr_data"}, int'(o_wr_data), 0);
        check({tag, "_busy"}, int'(o_busy), 0);
        check({tag, "_done"}, int'(o_done), 0);
        check({tag, "_zero_cnt"}, int'(o_zero_cnt), 0);
    endtask

    // Caller is in the posedge+1 phase of cycle 0; src_mem already holds the data.
    task automatic run_full(input int len, input int hold_at, input int hold_len,
                            input int restart_at);
        int  c0;
        int  busy_n;
        int  zeros;
        int  exp_busy;
        int  exp_zero;
        bit  seen;
        wr_t e;
        zeros = 0;
        for (int i = 0; i < len; i++) begin
            rq.push_back(i);
            e.addr = i;
            e.data = relu(src_mem[i]);
            wq.push_back(e);
            if (e.data == 32'd0) zeros++;
        end
        exp_zero = ZeroEn ? zeros : 0;
        exp_busy = (len == 0) ? 1 : len + 4 + hold_len;
        c0 = cyc;
        dq.push_back(c0 + exp_busy);
        runs_expected++;
        i_len   = 11'(len);
        i_start = 1'b1;
        busy_n  = 0;
        seen    = 1'b0;
        for (int k = 1; k <= len + 40 && !seen; k++) begin
            step();
            i_start = (k == restart_at);
            i_len   = (k == restart_at) ? 11'd2 : 11'(len + 3);
            i_hold  = (k >= hold_at) && (k < hold_at + hold_len);
            @(negedge clk);
            if (o_busy) busy_n++;
            if (o_done) seen = 1'b1;
        end
        i_start = 1'b0;
        i_hold  = 1'b0;
        check("done_seen", int'(seen), 1);
        check("busy_cycles", busy_n, exp_busy);
        step();
        check("busy_after_done", int'(o_busy), 0);
        check("zero_cnt_held", int'(o_zero_cnt), exp_zero);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got cycle %0d, expected completion", cyc);
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 1024; i++) src_mem[i] = 32'(i);
        rst = 1'b1; i_start = 1'b0; i_len = '0; i_abort = 1'b0; i_hold = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset");
        step();
        rst = 1'b0;
        step();

        // Mixed-sign map, no backpressure
        for (int i = 0; i < 8; i++) src_mem[i] = vec_a[i];
        run_full(8, 0, 0, 0);

        // Hold for three cycles after the second read
        for (int i = 0; i < 6; i++) src_mem[i] = vec_b[i];
        run_full(6, 4, 3, 0);

        // Empty map
        run_full(0, 0, 0, 0);

        // Abort on the third RUN cycle of a 10-element map
        for (int i = 0; i < 10; i++) src_mem[i] = 32'(i + 1);
        rd_chk  = 1'b0;
        i_len   = 11'd10;
        i_start = 1'b1;
        step();
        i_start = 1'b0;
        repeat (3) step();
        i_abort = 1'b1;
        @(negedge clk);
        check("abort_cycle_wr_en", int'(o_wr_en), 0);
        check("abort_cycle_clr", int'(o_relu_clr), 0);
        step();
        i_abort = 1'b0;
        @(negedge clk);
        check("abort_clr_pulse", int'(o_relu_clr), 1);
        check("abort_busy", int'(o_busy), 0);
        step();
        @(negedge clk);
        check("abort_clr_end", int'(o_relu_clr), 0);
        repeat (6) step();
        rd_chk = 1'b1;

        // New start accepted after abort
        for (int i = 0; i < 3; i++) src_mem[i] = vec_c[i];
        run_full(3, 0, 0, 0);

        // Second start and i_len change while busy are ignored
        for (int i = 0; i < 8; i++) src_mem[i] = vec_e[i];
        run_full(8, 0, 0, 3);

        // Reset in DRAIN: only the two writes before it may appear
        for (int i = 0; i < 4; i++) begin
            wr_t e;
            src_mem[i] = 32'(i + 1);
            rq.push_back(i);
            if (i < 2) begin
                e.addr = i;
                e.data = 32'(i + 1);
                wq.push_back(e);
            end
        end
        i_len   = 11'd4;
        i_start = 1'b1;
        step();
        i_start = 1'b0;
        repeat (5) step();
        rst = 1'b1;
        #1;
        check_all_zero("mid_rst");
        step();
        rst = 1'b0;
        repeat (4) step();
        check("post_rst_busy", int'(o_busy), 0);

        for (int i = 0; i < 2; i++) src_mem[i] = (i == 0) ? 32'd7 : 32'hFFFF_FFF9;
        run_full(2, 0, 0, 0);
        repeat (4) step();

        check("rd_queue_left", rq.size(), 0);
        check("wr_queue_left", wq.size(), 0);
        check("done_queue_left", dq.size(), 0);
        check("done_count", done_total, runs_expected);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
